multiword_adder_seq: RTL and testbench



---
 rtl/multiword_adder_seq.sv | 147 ++++++++++++++
 tb/tb_multiword_adder_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// Sequential multi-word adder: feeds a 4-bit carry-lookahead slice one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining MWADD_OVF_EN.

module Adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expanded in lookahead form rather than rippled through c[i].
  assign c[0]  = c_in;
  assign c[1]  = g[0] | (p[0] & c_in);
  assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum = p ^ c;
endmodule

module multiword_adder_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_c
`ifdef MWADD_OVF_EN
  ,
  output logic                 out_ovf
`endif
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   out_sum_q;
  logic               out_c_q;
  logic               out_valid_q;
  logic [3:0]         add_a;
  logic [3:0]         add_b;
  logic [3:0]         add_sum;
  logic               add_cout;

  assign add_a = a_q[4*idx_q +: 4];
  assign add_b = b_q[4*idx_q +: 4];

  Adder_4bit u_slice (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Partial result with the current slice merged in; committed to out_sum on the last slice.
  always_comb begin
    acc_d = acc_q;
    acc_d[4*idx_q +: 4] = add_sum;
  end

`ifdef MWADD_OVF_EN
  logic out_ovf_q;
  assign out_ovf = out_ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_c_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MWADD_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_c;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_d;
            out_c_q     <= add_cout;
`ifdef MWADD_OVF_EN
            // Carry into the MSB (recovered from the MSB sum bit) XOR carry out of it.
            out_ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_sum[3]) ^ add_cout;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_c     = out_c_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq: a NIBBLES=4 and a NIBBLES=1 instance on one clock.
// Checks out_ovf only when MWADD_OVF_EN is defined.

module tb_multiword_adder_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_c;
  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  in_a1;
  logic [3:0]  in_b1;
  logic        in_c1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  out_sum1;
  logic        out_c1;
`ifdef MWADD_OVF_EN
  logic        out_ovf;
  logic        out_ovf1;
`endif

  int checks = 0;
  int failures = 0;

  multiword_adder_seq #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c     (out_c)
`ifdef MWADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  multiword_adder_seq #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_c      (in_c1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_c     (out_c1)
`ifdef MWADD_OVF_EN
    ,
    .out_ovf   (out_ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, check latency and result, then consume it.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] exp_sum, input logic exp_c,
                       input logic exp_ovf);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    tick();
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
    in_c = ~c;
    repeat (3) tick();
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_c"}, 32'(out_c), 32'(exp_c));
`ifdef MWADD_OVF_EN
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unused");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_sum_hold"}, 32'(out_sum), 32'(exp_sum));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_c1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_c", 32'(out_c), 32'd0);
    check("rst_in_ready1", 32'(in_ready1), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    do_op("ripple", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("posovf", 16'h5353, 16'h3333, 1'b0, 16'h8686, 1'b0, 1'b1);
    do_op("fullcarry", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("ccaa", 16'hCCCC, 16'hAAAA, 1'b1, 16'h7777, 1'b1, 1'b1);

    // Backpressure: hold DONE for 10 cycles while a new request with changing data is offered.
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_c = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a = 16'(i * 16'h0731 + 16'h00F0);
      in_b = 16'h4444;
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'h3333);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_sum", 32'(out_sum), 32'h3333);

    // Reset while RUN is working on idx 2.
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h1111; in_c = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_c", 32'(out_c), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Single-nibble instance: one RUN cycle.
    check("n1_in_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_a1 = 4'hF; in_b1 = 4'h1; in_c1 = 1'b0;
    tick();
    in_valid1 = 1'b0;
    in_a1 = 4'h0;
    check("n1_early_valid", 32'(out_valid1), 32'd0);
    tick();
    check("n1_valid", 32'(out_valid1), 32'd1);
    check("n1_sum", 32'(out_sum1), 32'h0);
    check("n1_c", 32'(out_c1), 32'd1);
`ifdef MWADD_OVF_EN
    check("n1_ovf", 32'(out_ovf1), 32'd0);
`endif
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("n1_valid_drop", 32'(out_valid1), 32'd0);
    check("n1_ready_back", 32'(in_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
